// File: rtl/spi_master_arb.sv
// Round-robin arbiter sharing one SPI master packet port among N requesters.
// One owner per burst; ownership is held until all of that owner's reads return.
module spi_master_arb #(
    parameter int unsigned N        = 4,
    parameter int unsigned PW       = 104,
    parameter int unsigned MAXBURST = 16,
    parameter int unsigned MAXOUT   = 8,
    localparam int unsigned OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [N-1:0]      req_access,
    input  logic [N*PW-1:0]   req_packet,
    output logic [N-1:0]      req_wait,
    output logic [N-1:0]      rsp_access,
    output logic [PW-1:0]     rsp_packet,
    input  logic [N-1:0]      rsp_wait,
    output logic              spi_access,
    output logic [PW-1:0]     spi_packet,
    input  logic              spi_wait,
    input  logic              spi_rsp_access,
    input  logic [PW-1:0]     spi_rsp_packet,
    output logic              spi_rsp_wait,
    output logic [OW-1:0]     owner,
    output logic              err
);

    localparam int unsigned BW = $clog2(MAXBURST + 1);
    localparam int unsigned CW = $clog2(MAXOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   rr_q;
    logic [BW-1:0]   burst_q;
    logic [CW-1:0]   out_q, out_d;

    logic [PW-1:0]   own_pkt_c;
    logic [OW-1:0]   pick_c;
    logic            any_req_c;
    logic            found_c;
    logic            stall_c;
    logic            accept_c;
    logic            rd_acc_c;
    logic            rsp_fire_c;
    logic            dec_c;
    logic            last_c;
    logic            leave_c;

    // Owner packet mux, accept/stall qualification, round-robin pick, outstanding update
    always_comb begin
        own_pkt_c  = req_packet[int'(owner)*PW +: PW];
        any_req_c  = |req_access;
        pick_c     = '0;
        found_c    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            idx = (32'(rr_q) + i) % N;
            if (!found_c && req_access[idx]) begin
                found_c = 1'b1;
                pick_c  = OW'(idx);
            end
        end
        stall_c    = !own_pkt_c[0] && (out_q == CW'(MAXOUT));
        accept_c   = (state_q == BUSY) && req_access[owner] && !spi_wait && !stall_c;
        rd_acc_c   = accept_c && !own_pkt_c[0];
        rsp_fire_c = spi_rsp_access && !rsp_wait[owner];
        dec_c      = rsp_fire_c && (out_q != '0);
        out_d      = out_q;
        if (rd_acc_c && !dec_c) begin
            out_d = out_q + CW'(1);
        end else if (dec_c && !rd_acc_c) begin
            out_d = out_q - CW'(1);
        end
        last_c     = accept_c && (burst_q == BW'(MAXBURST - 1));
        leave_c    = (state_q == BUSY) && (!req_access[owner] || last_c);
    end

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = BUSY;
            BUSY:    if (leave_c) state_d = (out_d != '0) ? DRAIN : IDLE;
            DRAIN:   if (out_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: request-side handshake and readback routing
    always_comb begin
        req_wait     = '1;
        spi_access   = 1'b0;
        spi_packet   = own_pkt_c;
        rsp_access   = '0;
        rsp_access[owner] = spi_rsp_access;
        rsp_packet   = spi_rsp_packet;
        spi_rsp_wait = rsp_wait[owner];
        if (state_q == BUSY) begin
            spi_access      = req_access[owner];
            req_wait[owner] = spi_wait | stall_c;
        end
    end

    // Owner, round-robin pointer, burst and outstanding counters, sticky error
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            owner   <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            out_q   <= '0;
            err     <= 1'b0;
        end else begin
            out_q <= out_d;
            if (rsp_fire_c && (out_q == '0)) begin
                err <= 1'b1;
            end
            if ((state_q == IDLE) && any_req_c) begin
                owner <= pick_c;
            end
            if (leave_c) begin
                rr_q    <= (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
                burst_q <= '0;
            end else if (accept_c) begin
                burst_q <= burst_q + BW'(1);
            end
        end
    end

endmodule
